// File: rtl/timer_pkg.sv
// timer_pkg: register indices and CTRL bit positions shared by the timer MMIO block
package timer_pkg;
  localparam logic [1:0] TMR_CTRL = 2'd0;
  localparam logic [1:0] TMR_COUNT = 2'd1;
  localparam logic [1:0] TMR_COMPARE = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_PRESC_LSB = 16;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides enabled cycles by presc+1, pulsing tick on the last one
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);
  logic [PRESC_W-1:0] cnt;
  assign tick = en && cnt == presc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/timer_mmio_responder.sv
// timer_mmio_responder: memory-mapped prescaled up-counter with compare match and level irq
module timer_mmio_responder
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_dout,
  output logic        sel_q,
  output logic        irq
);
  localparam logic [31:0] CTRL_MASK = 32'h7 | ((32'hFFFF_FFFF >> (32 - PRESC_W)) << CTRL_PRESC_LSB);
  logic [31:0] ctrl, count, compare, rdata;
  logic match, hit, tick, hw_match, addr_unused;
  logic wr_ctrl, wr_count, wr_cmp, wr_stat;
  logic [1:0] idx;
  assign addr_unused = ^mem_addr[1:0];
  assign hit = mem_addr[31:4] == BASE_ADDR[31:4];
  assign idx = mem_addr[3:2];
  assign wr_ctrl = hit && mem_wen && idx == TMR_CTRL;
  assign wr_count = hit && mem_wen && idx == TMR_COUNT;
  assign wr_cmp = hit && mem_wen && idx == TMR_COMPARE;
  assign wr_stat = hit && mem_wen && idx == TMR_STATUS;
  assign hw_match = tick && count == compare;
  assign irq = match & ctrl[CTRL_IRQ_EN];
  always_comb
    rdata = idx == TMR_CTRL    ? ctrl :
            idx == TMR_COUNT   ? count :
            idx == TMR_COMPARE ? compare : {31'd0, match};
  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl[CTRL_EN]),
    .clr   (wr_ctrl),
    .presc (ctrl[CTRL_PRESC_LSB +: PRESC_W]),
    .tick  (tick)
  );
  // software writes to COUNT beat the tick; a hardware match beats a W1C
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ctrl <= '0;
      count <= '0;
      compare <= '0;
      match <= 1'b0;
      mem_dout <= '0;
      sel_q <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= mem_wdata & CTRL_MASK;
      if (wr_count) count <= mem_wdata;
      else if (tick) count <= hw_match && ctrl[CTRL_AUTO_RELOAD] ? '0 : count + 1'b1;
      if (wr_cmp) compare <= mem_wdata;
      if (hw_match) match <= 1'b1;
      else if (wr_stat && mem_wdata[0]) match <= 1'b0;
      mem_dout <= hit && mem_ren ? rdata : '0;
      sel_q <= hit && mem_ren;
    end
endmodule

// File: tb/tb_timer_mmio_responder.sv
// tb_timer_mmio_responder: directed stimulus against a per-cycle behavioural model plus literal checks
module tb_timer_mmio_responder;
  localparam logic [31:0] B = 32'hFFFF_0000;
  logic clk = 0, rst = 0, mem_ren = 0, mem_wen = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0;
  logic [31:0] mem_dout;
  logic sel_q, irq;
  int checks = 0, fails = 0;
  logic [31:0] m_ctrl = 0, m_count = 0, m_cmp = 0, m_dout = 0;
  logic [15:0] m_pcnt = 0;
  logic m_match = 0, m_sel = 0;

  timer_mmio_responder dut (
    .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_dout(mem_dout), .sel_q(sel_q), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("dout_vs_model", mem_dout, m_dout);
    check("sel_vs_model", {31'd0, sel_q}, {31'd0, m_sel});
    check("irq_vs_model", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
  end

  // one bus cycle: apply inputs, compute the model's state after the edge, commit after the edge
  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic hit, tick;
    logic [31:0] regs [4];
    logic [31:0] n_ctrl, n_count, n_cmp, n_dout;
    logic [15:0] n_pcnt;
    logic n_match, n_sel;
    mem_ren = r; mem_wen = w; mem_addr = a; mem_wdata = d;
    hit = a[31:4] == B[31:4];
    regs[0] = m_ctrl; regs[1] = m_count; regs[2] = m_cmp; regs[3] = {31'd0, m_match};
    tick = m_ctrl[0] && m_pcnt == m_ctrl[31:16];
    n_pcnt = !m_ctrl[0] ? m_pcnt : tick ? 16'd0 : m_pcnt + 16'd1;
    n_count = !tick ? m_count : (m_count == m_cmp && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
    n_match = m_match;
    n_ctrl = m_ctrl;
    n_cmp = m_cmp;
    if (hit && w && a[3:2] == 2'd3 && d[0]) n_match = 0;
    if (tick && m_count == m_cmp) n_match = 1;
    if (hit && w && a[3:2] == 2'd0) begin n_ctrl = d & 32'hFFFF_0007; n_pcnt = 0; end
    if (hit && w && a[3:2] == 2'd1) n_count = d;
    if (hit && w && a[3:2] == 2'd2) n_cmp = d;
    n_dout = (hit && r) ? regs[a[3:2]] : 32'd0;
    n_sel = hit && r;
    @(posedge clk);
    #2;
    m_ctrl = n_ctrl; m_count = n_count; m_cmp = n_cmp; m_match = n_match;
    m_pcnt = n_pcnt; m_dout = n_dout; m_sel = n_sel;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(0, 1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    cyc(1, 0, a, 0);
    check(name, mem_dout, exp);
  endtask

  task automatic do_reset();
    rst = 0;
    m_ctrl = 0; m_count = 0; m_cmp = 0; m_match = 0; m_pcnt = 0; m_dout = 0; m_sel = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ren = i[0]; mem_wen = i[1]; mem_addr = B + 32'(4 * i); mem_wdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #2;
    end
    mem_ren = 0; mem_wen = 0;
    rst = 1;
  endtask

  initial begin
    do_reset();
    rd(B + 0, 32'h0, "reset_ctrl");
    rd(B + 4, 32'h0, "reset_count");
    rd(B + 8, 32'h0, "reset_compare");
    rd(B + 12, 32'h0, "reset_status");
    // match without reload
    wr(B + 8, 5);
    wr(B + 0, 32'h5);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("irq_rise", {31'd0, irq}, {31'd0, i == 5});
    end
    rd(B + 4, 6, "count_after_match");
    check("irq_held", {31'd0, irq}, 32'd1);
    wr(B + 12, 1);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    wr(B + 0, 0);
    // auto-reload with prescale 3
    wr(B + 4, 0);
    wr(B + 8, 2);
    wr(B + 0, 32'h0003_0003);
    for (int j = 1; j <= 13; j++) rd(B + 4, 32'(((j - 1) / 4) % 3), "reload_count");
    wr(B + 12, 1);
    idle(12);
    rd(B + 12, 1, "reload_match");
    wr(B + 0, 0);
    // collisions
    wr(B + 12, 1);
    wr(B + 8, 1000);
    wr(B + 4, 50);
    wr(B + 0, 1);
    wr(B + 4, 100);
    rd(B + 4, 100, "count_write_wins");
    wr(B + 8, 103);
    idle(1);
    wr(B + 12, 1);
    rd(B + 12, 1, "match_beats_w1c");
    wr(B + 0, 0);
    // wrap
    wr(B + 12, 1);
    wr(B + 4, 32'hFFFF_FFFE);
    wr(B + 8, 3);
    wr(B + 0, 1);
    for (int j = 1; j <= 5; j++) rd(B + 4, 32'hFFFF_FFFE + 32'(j - 1), "wrap_count");
    rd(B + 12, 0, "wrap_no_match");
    rd(B + 12, 1, "wrap_match_at_3");
    wr(B + 0, 0);
    // decode
    rd(B + 16, 0, "miss_dout");
    check("miss_sel", {31'd0, sel_q}, 32'd0);
    wr(B + 4, 32'h1234);
    rd(B + 6, 32'h1234, "byte_bits_ignored");
    check("hit_sel", {31'd0, sel_q}, 32'd1);
    cyc(1, 1, B + 8, 77);
    check("ren_wen_old_value", mem_dout, 3);
    rd(B + 8, 77, "compare_written");
    // reset with irq pending
    wr(B + 8, 0);
    wr(B + 4, 0);
    wr(B + 0, 5);
    idle(1);
    check("irq_before_reset", {31'd0, irq}, 32'd1);
    do_reset();
    check("irq_after_reset", {31'd0, irq}, 32'd0);
    rd(B + 0, 0, "ctrl_after_reset");
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
